// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// uart_arb_pkg : shared state encoding and mode constants for UART arbiters
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

   localparam logic c_MODE_FIXED = 1'b0;
   localparam logic c_MODE_RR    = 1'b1;

   // Index width that stays legal for a single-client build.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational fixed-priority / round-robin request picker
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
   input  logic [NUM_CLIENTS-1:0] i_req,
   input  logic [IDX_W-1:0]       i_start,
   input  logic                   i_mode,
   output logic [NUM_CLIENTS-1:0] o_onehot,
   output logic [IDX_W-1:0]       o_idx,
   output logic                   o_valid
);

   int w_pos;

   // Round-robin scans from the slot after i_start; fixed mode scans from 0.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_pos    = 0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (i_mode == c_MODE_RR) begin
            w_pos = (int'(i_start) + 1 + k) % NUM_CLIENTS;
         end else begin
            w_pos = k;
         end
         if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
            o_valid = 1'b1;
            o_idx   = w_pos[IDX_W-1:0];
         end
      end
      if (o_valid) begin
         o_onehot[o_idx] = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : message-locked arbiter sharing one uart_tx among clients
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int RR_MODE     = 1,
   parameter int HOLD_LIMIT  = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CLIENTS-1:0]            cli_req,
   input  logic [NUM_CLIENTS-1:0]            cli_wr,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_din,
   output logic [NUM_CLIENTS-1:0]            cli_ready,
   output logic [NUM_CLIENTS-1:0]            grant,
   output logic                              uart_wr,
   output logic [DATA_WIDTH-1:0]             uart_din,
   input  logic                              uart_ready,
   output logic                              busy
);

   localparam int c_idx_w = idx_width(NUM_CLIENTS);
   localparam int c_cnt_w = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_limit     = c_cnt_w'(HOLD_LIMIT);
   localparam logic [c_idx_w-1:0] c_last_init = c_idx_w'(NUM_CLIENTS - 1);
   localparam logic               c_mode      = (RR_MODE != 0) ? c_MODE_RR : c_MODE_FIXED;

   arb_state_t              r_state;
   arb_state_t              w_state_nxt;
   logic [NUM_CLIENTS-1:0]  r_grant;
   logic [NUM_CLIENTS-1:0]  w_grant_nxt;
   logic [c_idx_w-1:0]      r_owner_idx;
   logic [c_idx_w-1:0]      w_owner_nxt;
   logic [c_idx_w-1:0]      r_last_owner;
   logic [c_idx_w-1:0]      w_last_nxt;
   logic                    w_new_grant;

   logic                    r_buf_valid;
   logic [DATA_WIDTH-1:0]   r_buf_data;
   logic [DATA_WIDTH-1:0]   r_din_hold;
   logic                    r_issued_last;
   logic [c_cnt_w-1:0]      r_count;

   logic [NUM_CLIENTS-1:0]  w_win_onehot;
   logic [c_idx_w-1:0]      w_win_idx;
   logic                    w_win_valid;
   logic                    w_quota_hit;
   logic                    w_owner_req;
   logic [DATA_WIDTH-1:0]   w_owner_din;
   logic                    w_accept;
   logic                    w_issue;

   rr_pick #(
      .NUM_CLIENTS (NUM_CLIENTS),
      .IDX_W       (c_idx_w)
   ) u_pick (
      .i_req    (cli_req),
      .i_start  (r_last_owner),
      .i_mode   (c_mode),
      .o_onehot (w_win_onehot),
      .o_idx    (w_win_idx),
      .o_valid  (w_win_valid)
   );

   assign w_quota_hit = (HOLD_LIMIT != 0) && (r_count == c_limit);
   assign w_owner_req = cli_req[r_owner_idx];
   assign w_owner_din = cli_din[r_owner_idx*DATA_WIDTH +: DATA_WIDTH];

   assign cli_ready = (r_state == ST_OWN && !r_buf_valid && !w_quota_hit) ? r_grant : '0;
   assign w_accept  = |(cli_wr & cli_ready);
   // issued_last masks the cycle where uart_tx may not yet have dropped ready.
   assign w_issue   = r_buf_valid & uart_ready & ~r_issued_last;

   assign grant    = r_grant;
   assign uart_wr  = w_issue;
   assign uart_din = w_issue ? r_buf_data : r_din_hold;
   assign busy     = (|r_grant) | r_buf_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_owner_idx  <= '0;
         r_last_owner <= c_last_init;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_owner_idx  <= w_owner_nxt;
         r_last_owner <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_owner_nxt = r_owner_idx;
      w_last_nxt  = r_last_owner;
      w_new_grant = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_win_valid) begin
               w_grant_nxt = w_win_onehot;
               w_owner_nxt = w_win_idx;
               w_new_grant = 1'b1;
               w_state_nxt = ST_OWN;
            end
         end
         ST_OWN: begin
            if (!w_owner_req || w_quota_hit) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!r_buf_valid && !w_issue) begin
               w_grant_nxt = '0;
               w_last_nxt  = r_owner_idx;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buf_valid   <= 1'b0;
         r_buf_data    <= '0;
         r_din_hold    <= '0;
         r_issued_last <= 1'b0;
         r_count       <= '0;
      end else begin
         r_issued_last <= w_issue;
         if (w_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= w_owner_din;
         end else if (w_issue) begin
            r_buf_valid <= 1'b0;
         end
         if (w_issue) begin
            r_din_hold <= r_buf_data;
         end
         if (w_new_grant) begin
            r_count <= '0;
         end else if (w_accept) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : scoreboard bench over RR, fixed and quota-limited builds
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int N_DUT = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req  [N_DUT];
   logic [1:0] wr   [N_DUT];
   logic [15:0] din [N_DUT];
   logic       urdy [N_DUT];
   logic [1:0] rdy  [N_DUT];
   logic [1:0] gnt  [N_DUT];
   logic       uwr  [N_DUT];
   logic [7:0] udin [N_DUT];
   logic       bsy  [N_DUT];

   typedef struct { int inst; logic [7:0] data; } exp_byte_t;
   typedef struct { int inst; logic [1:0] g;    } exp_grant_t;
   exp_byte_t  sb_q [$];
   exp_grant_t g_q  [$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // dut0: round-robin, dut1: fixed priority, dut2: round-robin with quota 2
   genvar d;
   generate
      for (d = 0; d < N_DUT; d++) begin : g_dut
         uart_tx_arbiter #(
            .NUM_CLIENTS (2),
            .DATA_WIDTH  (8),
            .RR_MODE     ((d == 1) ? 0 : 1),
            .HOLD_LIMIT  ((d == 2) ? 2 : 0)
         ) u_dut (
            .clk        (clk),
            .reset      (rst_n),
            .cli_req    (req[d]),
            .cli_wr     (wr[d]),
            .cli_din    (din[d]),
            .cli_ready  (rdy[d]),
            .grant      (gnt[d]),
            .uart_wr    (uwr[d]),
            .uart_din   (udin[d]),
            .uart_ready (urdy[d]),
            .busy       (bsy[d])
         );
      end
   endgenerate

   // Scoreboard monitor: pops expected bytes on each pulse and expected owners on each new grant.
   initial begin
      logic [1:0] pg [N_DUT];
      logic       pw [N_DUT];
      exp_byte_t  eb;
      exp_grant_t eg;
      for (int i = 0; i < N_DUT; i++) begin
         pg[i] = 2'b00;
         pw[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N_DUT; i++) begin
            if (rst_n) begin
               if (uwr[i]) begin
                  n_cmp++;
                  if (pw[i]) begin
                     n_bad++;
                     $display("FAIL wr_spacing dut%0d: uart_wr high on consecutive cycles, required a gap", i);
                  end
                  n_cmp++;
                  if (sb_q.size() == 0) begin
                     n_bad++;
                     $display("FAIL uart_byte dut%0d: got 0x%02h, required no pulse", i, udin[i]);
                  end else begin
                     eb = sb_q.pop_front();
                     if (eb.inst != i || eb.data !== udin[i]) begin
                        n_bad++;
                        $display("FAIL uart_byte: got dut%0d 0x%02h, required dut%0d 0x%02h", i, udin[i], eb.inst, eb.data);
                     end
                  end
               end
               if (gnt[i] != 2'b00 && pg[i] == 2'b00) begin
                  n_cmp++;
                  if (g_q.size() == 0) begin
                     n_bad++;
                     $display("FAIL grant_order dut%0d: got %b, required no grant", i, gnt[i]);
                  end else begin
                     eg = g_q.pop_front();
                     if (eg.inst != i || eg.g !== gnt[i]) begin
                        n_bad++;
                        $display("FAIL grant_order: got dut%0d %b, required dut%0d %b", i, gnt[i], eg.inst, eg.g);
                     end
                  end
               end else if (gnt[i] != 2'b00 && gnt[i] != pg[i]) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL grant_switch dut%0d: got %b after %b, required idle gap", i, gnt[i], pg[i]);
               end
            end
            pw[i] = uwr[i];
            pg[i] = gnt[i];
         end
      end
   end

   task automatic wait_grant(input int di, input int c, input logic v);
      int k = 0;
      while (gnt[di][c] !== v && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (gnt[di][c] !== v) begin
         n_bad++;
         $display("FAIL wait_grant dut%0d client%0d: got %b, required %b within 300 cycles", di, c, gnt[di][c], v);
      end
   endtask

   task automatic send_byte(input int di, input int c, input logic [7:0] b, input bit expect_out);
      int k = 0;
      while (!rdy[di][c] && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (!rdy[di][c]) begin
         n_bad++;
         $display("FAIL send_ready dut%0d client%0d: got ready 0, required 1 within 300 cycles", di, c);
      end else begin
         din[di][c*8 +: 8] = b;
         wr[di][c] = 1'b1;
         if (expect_out) sb_q.push_back('{di, b});
         @(posedge clk);
         @(negedge clk);
         wr[di][c] = 1'b0;
      end
   endtask

   task automatic drain_wait();
      int k = 0;
      while (sb_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d bytes outstanding, required 0", sb_q.size());
      end
   endtask

   task automatic client_msgs(input int di, input int c, input logic [7:0] base, input int n);
      for (int m = 0; m < n; m++) begin
         req[di][c] = 1'b1;
         wait_grant(di, c, 1'b1);
         send_byte(di, c, 8'(base + m), 1'b1);
         req[di][c] = 1'b0;
         wait_grant(di, c, 1'b0);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N_DUT; i++) begin
         req[i] = 2'b11;
         wr[i]  = 2'b00;
         din[i] = 16'h0000;
         urdy[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         n_cmp++; if (gnt[i] !== 2'b00) begin n_bad++; $display("FAIL reset_grant dut%0d: got %b, required 00", i, gnt[i]); end
         n_cmp++; if (rdy[i] !== 2'b00) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b, required 00", i, rdy[i]); end
         n_cmp++; if (uwr[i] !== 1'b0) begin n_bad++; $display("FAIL reset_wr dut%0d: got %b, required 0", i, uwr[i]); end
         n_cmp++; if (udin[i] !== 8'h00) begin n_bad++; $display("FAIL reset_din dut%0d: got 0x%02h, required 0x00", i, udin[i]); end
         n_cmp++; if (bsy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b, required 0", i, bsy[i]); end
         req[i] = 2'b00;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_rr_alternate();
      for (int m = 0; m < 3; m++) begin
         g_q.push_back('{0, 2'b01});
         g_q.push_back('{0, 2'b10});
      end
      fork
         client_msgs(0, 0, 8'hA0, 3);
         client_msgs(0, 1, 8'hB0, 3);
      join
      drain_wait();
   endtask

   task automatic test_single_msg();
      g_q.push_back('{0, 2'b01});
      req[0] = 2'b01;
      @(negedge clk);
      n_cmp++; if (gnt[0] !== 2'b01) begin n_bad++; $display("FAIL single_grant_latency: got %b, required 01", gnt[0]); end
      n_cmp++; if (rdy[0] !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b, required 01", rdy[0]); end
      send_byte(0, 0, 8'h41, 1'b1);
      send_byte(0, 0, 8'h42, 1'b1);
      drain_wait();
      @(negedge clk);
      req[0] = 2'b00;
      @(negedge clk);
      n_cmp++; if (gnt[0] !== 2'b01) begin n_bad++; $display("FAIL release_drain: got %b, required 01", gnt[0]); end
      @(negedge clk);
      n_cmp++; if (gnt[0] !== 2'b00) begin n_bad++; $display("FAIL release_idle: got %b, required 00", gnt[0]); end
      n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL release_busy: got %b, required 0", bsy[0]); end
   endtask

   task automatic test_nonowner();
      g_q.push_back('{0, 2'b01});
      req[0] = 2'b01;
      wait_grant(0, 0, 1'b1);
      din[0][15:8] = 8'hFF;
      wr[0][1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (rdy[0][1] !== 1'b0) begin n_bad++; $display("FAIL nonowner_ready: got %b, required 0", rdy[0][1]); end
      end
      send_byte(0, 0, 8'h61, 1'b1);
      drain_wait();
      wr[0][1] = 1'b0;
      @(negedge clk);
      req[0] = 2'b00;
      wait_grant(0, 0, 1'b0);
   endtask

   task automatic test_fixed_priority();
      for (int m = 0; m < 3; m++) g_q.push_back('{1, 2'b01});
      for (int m = 0; m < 3; m++) g_q.push_back('{1, 2'b10});
      fork
         client_msgs(1, 0, 8'hC0, 3);
         client_msgs(1, 1, 8'hD0, 3);
      join
      drain_wait();
   endtask

   task automatic test_quota();
      g_q.push_back('{2, 2'b10});
      g_q.push_back('{2, 2'b01});
      g_q.push_back('{2, 2'b10});
      g_q.push_back('{2, 2'b10});
      fork
         begin
            req[2][1] = 1'b1;
            wait_grant(2, 1, 1'b1);
            for (int k = 0; k < 5; k++) send_byte(2, 1, 8'(8'h30 + k), 1'b1);
            req[2][1] = 1'b0;
            wait_grant(2, 1, 1'b0);
         end
         begin
            wait_grant(2, 1, 1'b1);
            req[2][0] = 1'b1;
            wait_grant(2, 0, 1'b1);
            send_byte(2, 0, 8'h55, 1'b1);
            req[2][0] = 1'b0;
            wait_grant(2, 0, 1'b0);
         end
      join
      drain_wait();
   endtask

   task automatic test_reset_midwait();
      g_q.push_back('{0, 2'b01});
      urdy[0] = 1'b0;
      req[0] = 2'b01;
      wait_grant(0, 0, 1'b1);
      send_byte(0, 0, 8'h77, 1'b0);
      repeat (50) @(negedge clk);
      n_cmp++; if (bsy[0] !== 1'b1) begin n_bad++; $display("FAIL hold_busy: got %b, required 1", bsy[0]); end
      n_cmp++; if (uwr[0] !== 1'b0) begin n_bad++; $display("FAIL hold_wr: got %b, required 0", uwr[0]); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (gnt[0] !== 2'b00) begin n_bad++; $display("FAIL midreset_grant: got %b, required 00", gnt[0]); end
      n_cmp++; if (rdy[0] !== 2'b00) begin n_bad++; $display("FAIL midreset_ready: got %b, required 00", rdy[0]); end
      n_cmp++; if (uwr[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_wr: got %b, required 0", uwr[0]); end
      n_cmp++; if (udin[0] !== 8'h00) begin n_bad++; $display("FAIL midreset_din: got 0x%02h, required 0x00", udin[0]); end
      n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b, required 0", bsy[0]); end
      req[0] = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      urdy[0] = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL postreset_busy: got %b, required 0", bsy[0]); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_rr_alternate();
      test_single_msg();
      test_nonowner();
      test_fixed_priority();
      test_quota();
      test_reset_midwait();
      n_cmp++;
      if (sb_q.size() != 0) begin n_bad++; $display("FAIL leftover_bytes: got %0d, required 0", sb_q.size()); end
      n_cmp++;
      if (g_q.size() != 0) begin n_bad++; $display("FAIL leftover_grants: got %0d, required 0", g_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Parametrised, message-locked arbiter that shares one `uart_tx` instance among `NUM_CLIENTS` producers (board printer, user-input echo, future status/debug printers). It replaces the OR-merged `uart_wr`/`uart_din` glue at top level. Each client holds a request for a whole message. The arbiter grants the UART to one client at a time, buffers one byte, and forwards `uart_ready` only to the granted client. Fixed-priority and round-robin modes are selectable, with an optional byte quota per grant.

## Interface
- `NUM_CLIENTS`, 2: number of producers (1..8).
- `DATA_WIDTH`, 8: character width.
- `RR_MODE`, 1: 1 = round-robin, 0 = fixed priority (client 0 highest).
- `HOLD_LIMIT`, 0: max bytes per grant before forced re-arbitration; 0 = unlimited.

- `clk`  in  1  system clock (sysclk).
- `reset`  in  1  asynchronous, active-low reset.
- `cli_req`  in  NUM_CLIENTS  per-client message request/lock; level.
- `cli_wr`  in  NUM_CLIENTS  per-client byte strobe.
- `cli_din`  in  NUM_CLIENTS*DATA_WIDTH  client bytes; client i at [i*DATA_WIDTH +: DATA_WIDTH].
- `cli_ready`  out  NUM_CLIENTS  byte may be accepted from client i this cycle.
- `grant`  out  NUM_CLIENTS  one-hot current owner; all-zero when idle.
- `uart_wr`  out  1  single-cycle write pulse to `uart_tx`.
- `uart_din`  out  DATA_WIDTH  byte to `uart_tx`.
- `uart_ready`  in  1  `uart_tx` ready.
- `busy`  out  1  grant held or byte pending.

## Operation
- State machine has three states: IDLE, OWN, DRAIN.
- IDLE: if any `cli_req` is set, pick a winner and register `grant` one-hot, then go to OWN. Fixed mode picks the lowest index. RR mode picks the first requester after `last_owner` (wrapping modulo NUM_CLIENTS); `last_owner` resets to NUM_CLIENTS-1, so client 0 wins first.
- Byte buffer: one entry, `buf_valid`/`buf_data`. `cli_ready[i] = grant[i] & ~buf_valid & ~quota_hit` in OWN; 0 otherwise.
- Accept: on `cli_wr[i] & cli_ready[i]`, capture the byte and set `buf_valid`. `cli_wr` from a non-granted or not-ready client is ignored, never forwarded, and is not an error.
- Issue: when `buf_valid & uart_ready & ~issued_last`, pulse `uart_wr` with `uart_din = buf_data` and clear `buf_valid`. `issued_last` blocks re-issue in the cycle immediately after a pulse, which covers `uart_ready` lag. Accept and issue never overlap on the same cycle.
- Byte counter: counts accepted bytes in the current grant and is cleared on each new grant. `quota_hit` is `HOLD_LIMIT != 0 && count == HOLD_LIMIT`.
- OWN → DRAIN: on owner `cli_req` low, or on `quota_hit`.
- DRAIN: `grant` stays set and `cli_ready` is 0. When `buf_valid == 0` and no pulse occurred this cycle: clear `grant`, update `last_owner`, go to IDLE.
- Quota release: the owner is re-queued. In RR mode other requesters win next. In fixed mode, if it is still the highest requester, it may win again.
- Reset (any time, including mid-message): state IDLE, `buf_valid` 0, and any in-flight byte is dropped. Outputs reset to: `grant` 0, `cli_ready` 0, `uart_wr` 0, `uart_din` 0, `busy` 0. Counter resets to 0.

## Timing
- Request to grant: `grant` is visible 1 cycle after `cli_req` is sampled in IDLE. `cli_ready` is high the same cycle as `grant` if no quota is reached.
- Accept to `uart_wr`: 1 cycle minimum (registered); longer while `uart_ready` is low.
- Minimum spacing between `uart_wr` pulses: 2 cycles. In practice this is bounded by the UART frame time.
- Release: `cli_req` falling with the buffer empty → `grant` cleared 2 cycles later (OWN→DRAIN, DRAIN→IDLE). The earliest re-grant to another client follows 1 cycle after that.
- `uart_wr` is always exactly 1 cycle wide; `uart_din` holds its value until the next pulse.

## Structure
- `uart_arb_pkg`: state enum (IDLE/OWN/DRAIN) and the `RR_MODE` constants, shared with future arbiters such as an LED/VIO debug mux.
- Sub-module `rr_pick`: combinational priority picker. Inputs are the request vector, the start index and the mode bit; outputs are the one-hot winner and its index. It is reused by `game_manager` successors.

## Test plan
- N=2, RR, `cli_req`=01, client 0 sends 0x41, 0x42, then drops req → `uart_wr` pulses with 0x41 then 0x42; `grant` returns to 00 two cycles after req falls.
- Simultaneous `cli_req`=11, RR, each sends 1 byte per message, repeated 3 times → grant order 0,1,0,1,0,1.
- Same stimulus in fixed mode with client 0 re-requesting immediately → client 0 is granted three times in a row before client 1.
- HOLD_LIMIT=2, client 1 holds req and streams 0x30..0x34 while client 0 also requests → 0x30, 0x31 issued, then client 0 is granted, then client 1 resumes with 0x32.
- Non-owner `cli_wr` with data 0xFF during client 0 ownership → 0xFF never appears on `uart_din`; `cli_ready` for that client stays 0.
- `uart_ready` held low 50 cycles with a byte buffered, then `reset` pulled low mid-wait → no `uart_wr` pulse; all outputs are 0 the same cycle as reset assertion.
